// File: rtl/mode_step_counter.sv
// rtl/mode_step_counter.sv - debounced up/down mode stepping with a tick-driven step counter
// Optional: define MODE_STEP_COUNTER_SATURATE_EN to clamp the count instead of wrapping.
module mode_step_counter #(
  parameter int TICK_DIV        = 50_000_000,
  parameter int NUM_MODES       = 4,
  parameter int COUNT_WIDTH     = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                         in_clk,
  input  logic                         global_reset,
  input  logic                         in_up,
  input  logic                         in_down,
  input  logic                         in_clear,
  output logic [COUNT_WIDTH-1:0]       out_count,
  output logic [$clog2(NUM_MODES)-1:0] out_mode,
  output logic                         out_tick,
  output logic                         out_latch,
  output logic                         out_up_level,
  output logic                         out_down_level
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]             s1_q, s1_d, s2_q, s2_d;
  logic [1:0]             lvl_q, lvl_d, lvl_dly_q, lvl_dly_d;
  logic [DW-1:0]          db_cnt_q [2];
  logic [DW-1:0]          db_cnt_d [2];
  logic [1:0]             pulse;
  logic [MW-1:0]          mode_q, mode_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   tick_q, tick_d;
  logic                   latch_q, latch_d;
  logic [COUNT_WIDTH:0]   sum;
  logic                   tick_cond;

  always_comb begin
    s1_d      = {in_down, in_up};
    s2_d      = s1_q;
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (s2_q[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[b] = s2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  assign pulse = lvl_q & ~lvl_dly_q;

  // Coincident up and down pulses cancel.
  always_comb begin
    mode_d = mode_q;
    if (pulse == 2'b01 && mode_q != MW'(NUM_MODES - 1)) begin
      mode_d = mode_q + MW'(1);
    end else if (pulse == 2'b10 && mode_q != '0) begin
      mode_d = mode_q - MW'(1);
    end
  end

  assign tick_cond = (phase_q == PW'(TICK_DIV - 1));
  assign sum = (COUNT_WIDTH + 1)'(count_q) + (COUNT_WIDTH + 1)'(mode_q) + (COUNT_WIDTH + 1)'(1);

`ifndef MODE_STEP_COUNTER_SATURATE_EN
  logic unused_carry;
  assign unused_carry = sum[COUNT_WIDTH];
`endif

  always_comb begin
    phase_d = phase_q + PW'(1);
    count_d = count_q;
    tick_d  = 1'b0;
    latch_d = latch_q;
    if (in_clear) begin
      phase_d = '0;
      count_d = '0;
    end else if (tick_cond) begin
      phase_d = '0;
      tick_d  = 1'b1;
      latch_d = ~latch_q;
      // Step uses the mode as it was before any same-cycle change.
      if (mode_q != MW'(NUM_MODES - 1)) begin
`ifdef MODE_STEP_COUNTER_SATURATE_EN
        count_d = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
`else
        count_d = sum[COUNT_WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (global_reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      db_cnt_q  <= '{default: '0};
      mode_q    <= '0;
      phase_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      db_cnt_q  <= db_cnt_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      latch_q   <= latch_d;
    end
  end

  assign out_count      = count_q;
  assign out_mode       = mode_q;
  assign out_tick       = tick_q;
  assign out_latch      = latch_q;
  assign out_up_level   = lvl_q[0];
  assign out_down_level = lvl_q[1];

endmodule
